// File: rtl/registrador_universal.sv
// Universal N-bit register: hold/load/shift/rotate/clear plus burst sequencer.
// Optional registered even parity output enabled by REGISTRADOR_PARITY_EN.
module registrador_universal #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       mode,
  input  logic [N-1:0]     d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [N-1:0]     q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done,
  output logic             parity
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROTL  = 3'b100;
  localparam logic [2:0] M_ROTR  = 3'b101;
  localparam logic [2:0] M_CLEAR = 3'b110;

  state_t           state;
  state_t           state_n;
  logic [N-1:0]     q_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [2:0]       op;
  logic [2:0]       op_n;
  logic             busy_n;
  logic             done_n;
  logic             burst_req;
  logic             last_step;

  function automatic logic [N-1:0] apply_op(
    input logic [2:0]   m,
    input logic [N-1:0] v,
    input logic [N-1:0] ld,
    input logic         sl,
    input logic         sr
  );
    logic [N-1:0] r;
    r = v;
    case (m)
      M_HOLD:  r = v;
      M_LOAD:  r = ld;
      M_SHL:   r = {v[N-2:0], sl};
      M_SHR:   r = {sr, v[N-1:1]};
      M_ROTL:  r = {v[N-2:0], v[N-1]};
      M_ROTR:  r = {v[0], v[N-1:1]};
      M_CLEAR: r = '0;
      default: r = v;
    endcase
    return r;
  endfunction

  assign burst_req = start &&
                     (mode inside {M_SHL, M_SHR, M_ROTL, M_ROTR});
  assign last_step = (cnt == CNT_W'(1));

  always_comb begin
    state_n = state;
    q_n     = q;
    cnt_n   = cnt;
    op_n    = op;
    busy_n  = busy;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (burst_req) begin
          // start edge only latches; q untouched
          op_n  = mode;
          cnt_n = amount;
          if (amount != '0) begin
            busy_n  = 1'b1;
            state_n = RUN;
          end else begin
            done_n = 1'b1;
          end
        end else begin
          q_n = apply_op(mode, q, d, sin_l, sin_r);
        end
      end
      RUN: begin
        q_n   = apply_op(op, q, d, sin_l, sin_r);
        cnt_n = cnt - CNT_W'(1);
        if (last_step) begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      q     <= '0;
      cnt   <= '0;
      op    <= 3'b000;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      q     <= q_n;
      cnt   <= cnt_n;
      op    <= op_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  assign sout_l = q[N-1];
  assign sout_r = q[0];

`ifdef REGISTRADOR_PARITY_EN
  logic par_q;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^q_n;
    end
  end

  assign parity = par_q;
`else
  assign parity = 1'b0;
`endif

endmodule
